// File: rtl/data_mem_responder.sv
// Word-addressed data memory serving load/store requests from the memory stage.
// One request in flight; response appears LATENCY cycles after the accept edge.
module data_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              rd_p0;
  logic              wr_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              access;
  logic              acc_rd;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_err;
  logic              mem_we;

  function automatic logic req_err(input logic rd, input logic wr,
                                   input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != '0) || (rd == wr);
  endfunction

  assign accept = req_valid_i && req_ready_o;
  assign access = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd0));

  // With a one-cycle latency the access happens on the accept edge, so it
  // must use the live request rather than the not-yet-captured copy.
  assign acc_rd    = (state == IDLE) ? mem_read_i  : rd_p0;
  assign acc_wr    = (state == IDLE) ? mem_write_i : wr_p0;
  assign acc_addr  = (state == IDLE) ? addr_i      : addr_p0;
  assign acc_wdata = (state == IDLE) ? wdata_i     : wdata_p0;
  assign acc_idx   = acc_addr[IDX_W+1:2];
  assign acc_err   = req_err(acc_rd, acc_wr, acc_addr);
  assign mem_we    = access && !acc_err && acc_wr;

  // Stage p0: request capture
  always_ff @(posedge clk_i) begin
    if (accept) begin
      rd_p0    <= mem_read_i;
      wr_p0    <= mem_write_i;
      addr_p0  <= addr_i;
      wdata_p0 <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rdata_o     <= '0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (accept) begin
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (LATENCY == 1) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            rdata_o     <= '0;
            rsp_err_o   <= 1'b0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // Stage p1: access result, held until the response handshake
      if (access) begin
        rsp_err_o <= acc_err;
        rdata_o   <= (acc_err || !acc_rd) ? '0 : mem[acc_idx];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: four instances at latencies 2, 4, 1 and 15,
// directed scenarios plus random traffic checked against a word-array model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid [4];
  logic        req_ready [4];
  logic        rsp_valid [4];
  logic        rsp_err   [4];
  logic        busy      [4];
  logic [31:0] rdata     [4];
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_ready;

  int n_checks;
  int n_errors;

  logic [31:0] model_mem [4][256];
  bit          known     [4][256];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_mem_responder #(
      .ADDR_W (32),
      .DATA_W (32),
      .DEPTH  (256),
      .LATENCY(g == 0 ? 2 : g == 1 ? 4 : g == 2 ? 1 : 15)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_valid_i(req_valid[g]),
      .req_ready_o(req_ready[g]),
      .mem_read_i (mem_read),
      .mem_write_i(mem_write),
      .addr_i     (addr),
      .wdata_i    (wdata),
      .rsp_valid_o(rsp_valid[g]),
      .rsp_ready_i(rsp_ready),
      .rdata_o    (rdata[g]),
      .rsp_err_o  (rsp_err[g]),
      .busy_o     (busy[g])
    );
  end

  always #5 clk = ~clk;

  function automatic int lat_of(input int sel);
    case (sel)
      0:       return 2;
      1:       return 4;
      2:       return 1;
      default: return 15;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One full transaction on instance sel; stall = cycles the response is back-pressured.
  task automatic run_txn(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, input int stall);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] obs_rd;
    bit          chk_rd;
    int          n;
    int          idx;
    int          lat;
    lat     = lat_of(sel);
    idx     = int'(a[9:2]);
    exp_err = (a[1:0] != 2'b00) || (a >= 32'h400) || (rd == wr);
    chk_rd  = 1'b1;
    exp_rd  = 32'h0;
    if (!exp_err && rd) begin
      if (known[sel][idx]) exp_rd = model_mem[sel][idx];
      else chk_rd = 1'b0;
    end

    n = 0;
    while (!req_ready[sel] && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", req_ready[sel], 1'b1);

    mem_read       = rd;
    mem_write      = wr;
    addr           = a;
    wdata          = wd;
    rsp_ready      = (stall == 0);
    req_valid[sel] = 1'b1;
    @(negedge clk);
    req_valid[sel] = 1'b0;
    mem_read       = 1'($urandom);
    mem_write      = 1'($urandom);
    addr           = $urandom;
    wdata          = $urandom;

    n = 1;
    while (!rsp_valid[sel] && n < 40) begin
      check("req_ready_wait", req_ready[sel], 1'b0);
      @(negedge clk);
      n++;
    end
    check("latency", n, lat);
    if (!rsp_valid[sel]) begin
      rsp_ready = 1'b1;
      return;
    end
    obs_rd = rdata[sel];
    check("rsp_err", rsp_err[sel], exp_err);
    if (chk_rd) check("rdata", rdata[sel], exp_rd);
    check("busy_resp", busy[sel], 1'b1);
    check("req_ready_resp", req_ready[sel], 1'b0);

    for (int i = 0; i < stall; i++) begin
      req_valid[sel] = 1'b1;
      mem_read       = 1'b0;
      mem_write      = 1'b1;
      addr           = a;
      wdata          = ~wd;
      @(negedge clk);
      check("stall_valid", rsp_valid[sel], 1'b1);
      check("stall_rdata", rdata[sel], obs_rd);
      check("stall_err", rsp_err[sel], exp_err);
      check("stall_ready", req_ready[sel], 1'b0);
      check("stall_busy", busy[sel], 1'b1);
    end
    req_valid[sel] = 1'b0;
    rsp_ready      = 1'b1;
    @(negedge clk);
    check("post_valid", rsp_valid[sel], 1'b0);
    check("post_rdata", rdata[sel], 32'h0);
    check("post_err", rsp_err[sel], 1'b0);
    check("post_busy", busy[sel], 1'b0);
    check("post_ready", req_ready[sel], 1'b1);

    if (!exp_err && wr) begin
      model_mem[sel][idx] = wd;
      known[sel][idx]     = 1'b1;
    end
  endtask

  initial begin
    int          sel;
    int          pick;
    logic [31:0] a;
    logic        rd;
    logic        wr;
    clk       = 1'b0;
    rst_n     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    rsp_ready = 1'b1;
    n_checks  = 0;
    n_errors  = 0;
    for (int s = 0; s < 4; s++) begin
      req_valid[s] = 1'b0;
      for (int w = 0; w < 256; w++) known[s][w] = 1'b0;
    end

    // Reset asserted mid-cycle
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      check("rst_ready", req_ready[s], 1'b0);
      check("rst_valid", rsp_valid[s], 1'b0);
      check("rst_rdata", rdata[s], 32'h0);
      check("rst_err", rsp_err[s], 1'b0);
      check("rst_busy", busy[s], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 4; s++) check("ready_after_rst", req_ready[s], 1'b1);

    // Store then load, latency 2
    run_txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    run_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 0);
    // Back-pressure with a competing request during the stall
    run_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 5);
    run_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 0);
    // Error cases, then confirm the word is intact
    run_txn(0, 1'b0, 1'b1, 32'h13, 32'h55555555, 0);
    run_txn(0, 1'b0, 1'b1, 32'h400, 32'h66666666, 0);
    run_txn(0, 1'b1, 1'b1, 32'h10, 32'h77777777, 0);
    run_txn(0, 1'b0, 1'b0, 32'h10, 32'h88888888, 0);
    run_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 0);
    // Boundary word
    run_txn(0, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 0);
    run_txn(0, 1'b0, 1'b1, 32'h3FC, 32'h12345678, 0);
    run_txn(0, 1'b1, 1'b0, 32'h3FC, 32'h0, 0);
    run_txn(0, 1'b1, 1'b0, 32'h0, 32'h0, 0);

    // Reset before the access edge drops the store, latency 4
    run_txn(1, 1'b0, 1'b1, 32'h20, 32'h11111111, 0);
    mem_read     = 1'b0;
    mem_write    = 1'b1;
    addr         = 32'h20;
    wdata        = 32'hAAAA5555;
    req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("midop_busy", busy[1], 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midop_rst_valid", rsp_valid[1], 1'b0);
    check("midop_rst_busy", busy[1], 1'b0);
    check("midop_rst_ready", req_ready[1], 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midop_no_rsp", rsp_valid[1], 1'b0);
    end
    run_txn(1, 1'b1, 1'b0, 32'h20, 32'h0, 0);

    // Latency extremes
    run_txn(2, 1'b0, 1'b1, 32'h44, 32'h0BADF00D, 0);
    run_txn(2, 1'b1, 1'b0, 32'h44, 32'h0, 0);
    run_txn(2, 1'b1, 1'b0, 32'h44, 32'h0, 2);
    run_txn(3, 1'b0, 1'b1, 32'h48, 32'hFEEDFACE, 0);
    run_txn(3, 1'b1, 1'b0, 32'h48, 32'h0, 0);
    run_txn(3, 1'b0, 1'b1, 32'h4A, 32'h1, 0);

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      sel  = int'($urandom_range(0, 3));
      pick = int'($urandom_range(0, 9));
      case (pick)
        0:       a = 32'h10;
        1:       a = 32'h3FC;
        2:       a = 32'h0;
        3:       a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        4:       a = 32'h400 + ($urandom & 32'hFFFF_FFFC);
        default: a = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
      endcase
      pick = int'($urandom_range(0, 9));
      rd   = (pick < 5) || (pick == 9);
      wr   = (pick >= 4) && (pick != 9) ? (pick != 4) : (pick == 8);
      if (pick == 4) wr = 1'b1;
      run_txn(sel, rd, wr, a, $urandom, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
